// File: rtl/fixture_stream_fifo.sv
// Valid/ready stream FIFO: stores up to DEPTH words of WIDTH bits and replays them in order.
// Optional FIXTURE_FIFO_STATS_EN adds 16-bit push/pop event counters.
module fixture_stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       sync_rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
`ifdef FIXTURE_FIFO_STATS_EN
  output logic                       empty,
  output logic [15:0]                push_count,
  output logic [15:0]                pop_count
`else
  output logic                       empty
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full_int, empty_int;
  logic             push, pop;

  // Status is decoded from registered level only, so no ready/valid combinational paths exist.
  always_comb begin
    full_int  = (level_q == LvlW'(DEPTH));
    empty_int = (level_q == '0);
    push      = in_valid & ~full_int;
    pop       = out_ready & ~empty_int;
  end

  // Pointers are PtrW bits wide and DEPTH is a power of two, so increment wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left uncleared by reset; a reset-cycle push must still not land.
  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    in_ready  = ~full_int;
    out_valid = ~empty_int;
    out_data  = empty_int ? '0 : mem_q[rd_ptr_q];
    level     = level_q;
    full      = full_int;
    empty     = empty_int;
  end

`ifdef FIXTURE_FIFO_STATS_EN
  logic [15:0] push_count_q, push_count_d;
  logic [15:0] pop_count_q, pop_count_d;

  always_comb begin
    push_count_d = push_count_q + {15'd0, push};
    pop_count_d  = pop_count_q + {15'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      push_count_q <= '0;
      pop_count_q  <= '0;
    end else begin
      push_count_q <= push_count_d;
      pop_count_q  <= pop_count_d;
    end
  end

  always_comb begin
    push_count = push_count_q;
    pop_count  = pop_count_q;
  end
`endif

endmodule

// File: tb/tb_fixture_stream_fifo.sv
// Self-checking bench for fixture_stream_fifo: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_fixture_stream_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);

  logic             clk;
  logic             sync_rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LvlW-1:0]  level;
  logic             full;
  logic             empty;
`ifdef FIXTURE_FIFO_STATS_EN
  logic [15:0]      push_count;
  logic [15:0]      pop_count;
`endif

  fixture_stream_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .full      (full),
`ifdef FIXTURE_FIFO_STATS_EN
    .empty     (empty),
    .push_count(push_count),
    .pop_count (pop_count)
`else
    .empty     (empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: contents as a plain queue, counters as plain integers.
  int unsigned model_q[$];
  int unsigned model_push_cnt;
  int unsigned model_pop_cnt;
  int unsigned popped[$];
  bit          hold_pend;
  int unsigned hold_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    int unsigned sz;
    sz = model_q.size();
    check({tag, "_level"}, 64'(level), 64'(sz));
    check({tag, "_empty"}, 64'(empty), 64'(sz == 0));
    check({tag, "_full"}, 64'(full), 64'(sz == DEPTH));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(sz != DEPTH));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(sz != 0));
    check({tag, "_out_data"}, 64'(out_data), 64'((sz != 0) ? model_q[0] : 0));
`ifdef FIXTURE_FIFO_STATS_EN
    check({tag, "_push_count"}, 64'(push_count), 64'(model_push_cnt % 65536));
    check({tag, "_pop_count"}, 64'(pop_count), 64'(model_pop_cnt % 65536));
`endif
  endtask

  // One clock: drive inputs, check the pre-edge state, advance the model across the edge.
  task automatic cycle(input string tag, input bit iv, input int unsigned d, input bit ordy,
                       input bit rst);
    bit m_push;
    bit m_pop;
    if (hold_pend) begin
      check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_hold_data"}, 64'(out_data), 64'(hold_data));
    end
    in_valid  = iv;
    in_data   = WIDTH'(d);
    out_ready = ordy;
    sync_rst  = rst;
    check_state(tag);
    m_push    = iv && (model_q.size() < DEPTH);
    m_pop     = ordy && (model_q.size() > 0);
    hold_pend = (model_q.size() > 0) && !ordy && !rst;
    hold_data = (model_q.size() > 0) ? model_q[0] : 0;
    if (m_pop && out_valid) popped.push_back(int'(out_data));
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      model_push_cnt = 0;
      model_pop_cnt  = 0;
      hold_pend      = 1'b0;
    end else begin
      if (m_pop) begin
        void'(model_q.pop_front());
        model_pop_cnt++;
      end
      if (m_push) begin
        model_q.push_back(d % (1 << WIDTH));
        model_push_cnt++;
      end
    end
  endtask

  typedef struct {
    bit          iv;
    int unsigned d;
    bit          ordy;
    int unsigned exp_level;
    bit          exp_out_valid;
    int unsigned exp_out_data;
    bit          exp_full;
  } vec_t;

  vec_t vecs[9];

  initial begin
    checks         = 0;
    failures       = 0;
    model_push_cnt = 0;
    model_pop_cnt  = 0;
    hold_pend      = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b0;
    sync_rst       = 1'b1;

    // Fill-to-full, rejected fifth word, then drain; expectations are after each edge.
    vecs[0] = '{1, 'hA1, 0, 1, 1, 'hA1, 0};
    vecs[1] = '{1, 'hA2, 0, 2, 1, 'hA1, 0};
    vecs[2] = '{1, 'hA3, 0, 3, 1, 'hA1, 0};
    vecs[3] = '{1, 'hA4, 0, 4, 1, 'hA1, 1};
    vecs[4] = '{1, 'hA5, 0, 4, 1, 'hA1, 1};
    vecs[5] = '{0, 'h00, 1, 3, 1, 'hA2, 0};
    vecs[6] = '{0, 'h00, 1, 2, 1, 'hA3, 0};
    vecs[7] = '{0, 'h00, 1, 1, 1, 'hA4, 0};
    vecs[8] = '{0, 'h00, 1, 0, 0, 'h00, 0};

    // Test 1: reset then idle
    repeat (2) @(posedge clk);
    #1;
    sync_rst = 1'b0;
    @(posedge clk);
    #1;
    check("t1_level", 64'(level), 64'(0));
    check("t1_empty", 64'(empty), 64'(1));
    check("t1_full", 64'(full), 64'(0));
    check("t1_in_ready", 64'(in_ready), 64'(1));
    check("t1_out_valid", 64'(out_valid), 64'(0));
    check("t1_out_data", 64'(out_data), 64'(0));

    // Test 2: table-driven fill/drain
    for (int i = 0; i < 9; i++) begin
      cycle($sformatf("t2_v%0d", i), vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
      check($sformatf("t2_v%0d_tbl_level", i), 64'(level), 64'(vecs[i].exp_level));
      check($sformatf("t2_v%0d_tbl_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
      check($sformatf("t2_v%0d_tbl_out_data", i), 64'(out_data), 64'(vecs[i].exp_out_data));
      check($sformatf("t2_v%0d_tbl_full", i), 64'(full), 64'(vecs[i].exp_full));
    end
    popped.delete();

    // Test 3: single-word latency
    check("t3_before_valid", 64'(out_valid), 64'(0));
    cycle("t3_push", 1'b1, 'h5C, 1'b0, 1'b0);
    check("t3_after_valid", 64'(out_valid), 64'(1));
    check("t3_after_data", 64'(out_data), 64'('h5C));
    cycle("t3_pop", 1'b0, 0, 1'b1, 1'b0);
    check("t3_level_zero", 64'(level), 64'(0));

    // Test 4: continuous streaming through five pointer laps
    popped.delete();
    for (int i = 0; i < 20; i++) begin
      cycle("t4", 1'b1, i, 1'b1, 1'b0);
      check("t4_level_le1", 64'(level <= 1), 64'(1));
    end
    cycle("t4_drain", 1'b0, 0, 1'b1, 1'b0);
    check("t4_count", 64'(popped.size()), 64'(20));
    for (int i = 0; i < 20; i++) begin
      if (i < popped.size()) check($sformatf("t4_seq%0d", i), 64'(popped[i]), 64'(i));
    end

    // Test 5: randomized handshakes against the model
    for (int i = 0; i < 2000; i++) begin
      cycle("t5", 1'($urandom_range(0, 1)), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
            1'b0);
    end
    check("t5_level_vs_counts", 64'(level), 64'(model_push_cnt - model_pop_cnt));

    // Test 6: reset mid-stream with a concurrent push
    while (model_q.size() > 0) cycle("t6_flush", 1'b0, 0, 1'b1, 1'b0);
    cycle("t6_load0", 1'b1, 'h11, 1'b0, 1'b0);
    cycle("t6_load1", 1'b1, 'h22, 1'b0, 1'b0);
    cycle("t6_load2", 1'b1, 'h33, 1'b0, 1'b0);
    check("t6_loaded_level", 64'(level), 64'(3));
    cycle("t6_rst", 1'b1, 'h44, 1'b0, 1'b1);
    check("t6_level", 64'(level), 64'(0));
    check("t6_empty", 64'(empty), 64'(1));
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_out_data", 64'(out_data), 64'(0));
`ifdef FIXTURE_FIFO_STATS_EN
    check("t6_push_count", 64'(push_count), 64'(0));
    check("t6_pop_count", 64'(pop_count), 64'(0));
`endif
    cycle("t6_after", 1'b1, 'h55, 1'b1, 1'b0);
    cycle("t6_after2", 1'b0, 0, 1'b1, 1'b0);
    check_state("t6_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
